// File: rtl/alu_frame_crc_engine.sv
// Frame CRC generator/checker: folds NUM_WORDS data words plus a tail through
// a parametrised LFSR CRC and returns the CRC or a check-mode mismatch flag.
module alu_frame_crc_engine #(
  parameter int               DATA_W    = 32,
  parameter int               NUM_WORDS = 2,
  parameter int               TAIL_W    = 4,
  parameter int               CRC_W     = 4,
  parameter logic [CRC_W-1:0] POLY      = 4'h3,
  parameter logic [CRC_W-1:0] INIT      = 4'h0,
  localparam int              TW        = (TAIL_W > 0) ? TAIL_W : 1,
  localparam int              CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic [TW-1:0]     in_tail,
  input  logic [CRC_W-1:0]  in_crc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_err,
  output logic              out_mode
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  logic [1:0]       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;

  logic             accept, first, last, fmode;
  logic [CRC_W-1:0] nxt;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
    logic fb;
    fb = c[CRC_W-1] ^ d;
    return (c << 1) ^ (fb ? POLY : '0);
  endfunction

  // A result slot is free unless a pending result is not being drained this cycle.
  assign in_ready = !rst && !flush && ((state_q != OUT) || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    first = (state_q != ACCUM);
    fmode = first ? in_mode : mode_q;
    last  = first ? (NUM_WORDS == 1) : (cnt_q == CNT_W'(NUM_WORDS - 1));
    nxt   = first ? INIT : crc_q;
    for (int i = DATA_W - 1; i >= 0; i--) nxt = crc_step(nxt, in_data[i]);
    if (last)
      for (int i = TAIL_W - 1; i >= 0; i--) nxt = crc_step(nxt, in_tail[i]);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      if (rst) begin
        mode_q   <= 1'b0;
        out_crc  <= INIT;
        out_err  <= 1'b0;
        out_mode <= 1'b0;
      end
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        state_q   <= IDLE;
      end
      if (accept) begin
        if (last) begin
          out_crc   <= nxt;
          out_err   <= fmode && (nxt != in_crc);
          out_mode  <= fmode;
          out_valid <= 1'b1;
          state_q   <= OUT;
          crc_q     <= INIT;
          cnt_q     <= '0;
        end else begin
          crc_q   <= nxt;
          mode_q  <= fmode;
          state_q <= ACCUM;
          cnt_q   <= first ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_crc_engine.sv
// Bench: default CRC4 instance with spec vectors and corner sequences, plus a
// CRC8/3-word/no-tail instance checked against a polynomial long-division model.
module tb_alu_frame_crc_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // instance A: defaults
  logic        a_in_valid = 0, a_in_ready, a_in_mode = 0, a_out_valid, a_out_ready = 1;
  logic        a_out_err, a_out_mode;
  logic [31:0] a_in_data = 0;
  logic [3:0]  a_in_tail = 0, a_in_crc = 0, a_out_crc;

  alu_frame_crc_engine dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_tail(a_in_tail), .in_crc(a_in_crc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_crc(a_out_crc),
    .out_err(a_out_err), .out_mode(a_out_mode));

  // instance B: CRC-8 poly 0x07, 3 words, no tail
  logic        b_in_valid = 0, b_in_ready, b_in_mode = 0, b_out_valid, b_out_ready = 1;
  logic        b_out_err, b_out_mode;
  logic [31:0] b_in_data = 0;
  logic [0:0]  b_in_tail = 0;
  logic [7:0]  b_in_crc = 0, b_out_crc;

  alu_frame_crc_engine #(.DATA_W(32), .NUM_WORDS(3), .TAIL_W(0), .CRC_W(8),
                         .POLY(8'h07), .INIT(8'h00)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_tail(b_in_tail), .in_crc(b_in_crc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_crc(b_out_crc),
    .out_err(b_out_err), .out_mode(b_out_mode));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^k mod P(x) (valid for INIT = 0).
  function automatic logic [7:0] ref_crc(input bit q[$], input int k, input logic [7:0] poly);
    logic [15:0] rem;
    bit b;
    rem = '0;
    for (int i = 0; i < q.size() + k; i++) begin
      b = (i < q.size()) ? q[i] : 1'b0;
      rem = {rem[14:0], b};
      if (rem[k]) rem = rem ^ ((16'd1 << k) | 16'(poly));
    end
    return rem[7:0] & 8'((16'd1 << k) - 1);
  endfunction

  task automatic push_a(input logic [31:0] d, input logic m, input logic [3:0] t, input logic [3:0] c);
    int n = 0;
    a_in_valid = 1; a_in_data = d; a_in_mode = m; a_in_tail = t; a_in_crc = c;
    #1;
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL push_a_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    a_in_valid = 0;
  endtask

  task automatic push_b(input logic [31:0] d, input logic m, input logic [7:0] c);
    int n = 0;
    b_in_valid = 1; b_in_data = d; b_in_mode = m; b_in_crc = c;
    #1;
    while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL push_b_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    b_in_valid = 0;
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] w0, w1;
    logic [3:0]  tail, crc_in, exp_crc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit          q[$];
    logic [31:0] w[3];
    logic [7:0]  e8, c8;
    logic [3:0]  e4, t4;
    logic        m;

    vecs[0] = '{1'b0, 32'h0, 32'h0, 4'h1, 4'h0, 4'h3, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 32'h1, 4'h0, 4'h0, 4'h5, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 32'h0, 4'h0, 4'hF, 4'h0, 1'b0};
    vecs[3] = '{1'b1, 32'h0, 32'h0, 4'h1, 4'h3, 4'h3, 1'b0};
    vecs[4] = '{1'b1, 32'h0, 32'h0, 4'h1, 4'h4, 4'h3, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_crc", a_out_crc, 0);
    chk("rst_out_err", a_out_err, 0);
    chk("rst_out_mode", a_out_mode, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 1);

    // table vectors, back to back
    foreach (vecs[i]) begin
      push_a(vecs[i].w0, vecs[i].mode, 4'hA, 4'hA);
      chk($sformatf("v%0d_mid_valid", i), a_out_valid, 0);
      push_a(vecs[i].w1, ~vecs[i].mode, vecs[i].tail, vecs[i].crc_in);
      chk($sformatf("v%0d_valid", i), a_out_valid, 1);
      chk($sformatf("v%0d_crc", i), a_out_crc, vecs[i].exp_crc);
      chk($sformatf("v%0d_err", i), a_out_err, vecs[i].exp_err);
      chk($sformatf("v%0d_mode", i), a_out_mode, vecs[i].mode);
    end

    // output stall, then drain with a new word 0 in the same cycle
    push_a(32'h0, 1'b0, 4'h0, 4'h0);
    push_a(32'h0, 1'b0, 4'h1, 4'h0);
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h0; a_in_mode = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", a_out_valid, 1);
      chk("stall_crc", a_out_crc, 4'h3);
      chk("stall_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1;
    #1 chk("drain_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    chk("drain_consumed", a_out_valid, 0);
    push_a(32'h1, 1'b0, 4'h0, 4'h0);
    chk("b2b_valid", a_out_valid, 1);
    chk("b2b_crc", a_out_crc, 4'h5);

    // flush after word 0; simultaneous word is discarded
    @(posedge clk); #1;
    push_a(32'hDEAD_BEEF, 1'b0, 4'h0, 4'h0);
    flush = 1; a_in_valid = 1; a_in_data = 32'h5;
    #1 chk("flush_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    flush = 0; a_in_valid = 0;
    chk("flush_valid", a_out_valid, 0);
    push_a(32'h0, 1'b0, 4'h0, 4'h0);
    chk("flush_resume_mid_valid", a_out_valid, 0);
    push_a(32'h0, 1'b0, 4'h1, 4'h0);
    chk("flush_resume_crc", a_out_crc, 4'h3);
    chk("flush_resume_valid", a_out_valid, 1);

    // reset mid-frame
    @(posedge clk); #1;
    push_a(32'h7, 1'b1, 4'h0, 4'h0);
    rst = 1;
    @(posedge clk); #1;
    chk("rstmid_in_ready", a_in_ready, 0);
    chk("rstmid_valid", a_out_valid, 0);
    chk("rstmid_crc", a_out_crc, 0);
    rst = 0;
    push_a(32'h0, 1'b0, 4'h0, 4'h0);
    chk("rstmid_resume_mid_valid", a_out_valid, 0);
    push_a(32'h1, 1'b0, 4'h0, 4'h0);
    chk("rstmid_resume_crc", a_out_crc, 4'h5);

    // reset while a check-mode error result is pending
    @(posedge clk); #1;
    a_out_ready = 0;
    push_a(32'h0, 1'b1, 4'h0, 4'h0);
    push_a(32'h0, 1'b0, 4'h1, 4'h4);
    chk("pend_err", a_out_err, 1);
    chk("pend_mode", a_out_mode, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rstout_valid", a_out_valid, 0);
    chk("rstout_crc", a_out_crc, 0);
    chk("rstout_err", a_out_err, 0);
    chk("rstout_mode", a_out_mode, 0);
    rst = 0;
    a_out_ready = 1;

    // random frames on instance A (with tail)
    for (int f = 0; f < 12; f++) begin
      w[0] = $urandom; w[1] = $urandom; t4 = 4'($urandom); m = 1'($urandom);
      q.delete();
      for (int j = 0; j < 2; j++) for (int b = 31; b >= 0; b--) q.push_back(w[j][b]);
      for (int b = 3; b >= 0; b--) q.push_back(t4[b]);
      e4 = 4'(ref_crc(q, 4, 8'h03));
      c8 = 8'(($urandom_range(0, 1) != 0) ? e4 : e4 ^ 4'(1 + $urandom_range(0, 14)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 push_a(w[0], m, 4'($urandom), 4'($urandom));
      push_a(w[1], 1'($urandom), t4, c8[3:0]);
      chk("rand_a_crc", a_out_crc, e4);
      chk("rand_a_err", a_out_err, m && (c8[3:0] != e4));
    end

    // random frames on instance B
    for (int f = 0; f < 30; f++) begin
      m = 1'($urandom);
      q.delete();
      for (int j = 0; j < 3; j++) begin
        w[j] = (f == 0) ? 32'h0 : $urandom;
        for (int b = 31; b >= 0; b--) q.push_back(w[j][b]);
      end
      e8 = ref_crc(q, 8, 8'h07);
      c8 = ($urandom_range(0, 1) != 0) ? e8 : e8 ^ 8'(1 + $urandom_range(0, 254));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 push_b(w[0], m, 8'($urandom));
      push_b(w[1], 1'($urandom), 8'($urandom));
      chk("rand_b_mid_valid", b_out_valid, 0);
      push_b(w[2], 1'($urandom), c8);
      chk("rand_b_valid", b_out_valid, 1);
      chk("rand_b_crc", b_out_crc, e8);
      chk("rand_b_err", b_out_err, m && (c8 != e8));
      chk("rand_b_mode", b_out_mode, m);
    end

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
